// File: rtl/tx_fifo_pkg.sv
// tx_fifo_pkg: shared types and defaults for the packet-aware transmit FIFO.
//   state_t       - read-side FSM states (IDLE, READY, SEND, GAP)
//   fifo_entry_t  - one stored entry: {last, data}
//   DEFAULT_DEPTH / DEFAULT_IFG_CYCLES - default parameter values
package tx_fifo_pkg;

    localparam int DEFAULT_DEPTH      = 64;
    localparam int DEFAULT_IFG_CYCLES = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        SEND  = 2'd2,
        GAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/tx_fifo_ram.sv
// tx_fifo_ram: DEPTH x 9 simple dual-port RAM for the transmit FIFO.
// Ports:
//   clk, rst     - clock; asynchronous active-high reset (output register only)
//   we/waddr/wdata - synchronous write port
//   re/raddr     - read port; rdata is the registered data byte of the entry
//   rlast_peek   - last flag of the entry at raddr, available in the same
//                  cycle so the reader can leave SEND on the edge that
//                  pops the final byte
module tx_fifo_ram
    import tx_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  fifo_entry_t              wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [7:0]               rdata,
    output logic                     rlast_peek
);

    fifo_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr].data;
        end
    end

    assign rlast_peek = mem[raddr].last;

endmodule

// File: rtl/tx_packet_fifo.sv
// tx_packet_fifo: packet-aware transmit buffer between the USB receive path
// and mac_transmitter. Only committed packets (terminated by wr_last) are
// offered to the MAC, and an inter-frame gap is enforced between packets.
//
// Optional feature macro: TX_FIFO_OVF_DROP_EN
//   defined   - a packet that lost bytes to overflow is discarded at commit
//   undefined - the truncated packet is committed with its last flag forced
//
// Ports:
//   clk, reset            - single clock; asynchronous active-high reset
//   wr_en/wr_data/wr_last - write side; wr_last marks and commits a packet
//   full                  - no free entry (combinational from pointers)
//   overflow              - pulse during the wr_last write of a packet that lost bytes
//   data_ready            - pulse in the cycle a packet is offered (IDLE/GAP -> READY)
//   rd_start              - MAC accepts the offered packet (READY only)
//   rd_en                 - pop one byte (SEND only, ignored when fifo_empty)
//   rd_data               - registered byte, valid the cycle after rd_en
//   fifo_empty            - no further bytes of the current packet
//   pkt_count             - committed packets not yet started
//   dbg_state             - read FSM state
//
// Read handshake: data_ready is an offer with no wait requirement; the FSM
// stays in READY until rd_start. In SEND, each cycle with rd_en=1 and
// fifo_empty=0 is one transfer, and the byte appears on rd_data after the
// next edge. fifo_empty rises on the same edge that presents the last byte.
module tx_packet_fifo
    import tx_fifo_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int IFG_CYCLES = DEFAULT_IFG_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   wr_last,
    output logic                   full,
    output logic                   overflow,
    output logic                   data_ready,
    input  logic                   rd_start,
    input  logic                   rd_en,
    output logic [7:0]             rd_data,
    output logic                   fifo_empty,
    output logic [$clog2(DEPTH):0] pkt_count,
    output state_t                 dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] commit_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_prev;
    logic [PW-1:0] wr_ptr_after;
    logic          ovf_pend;
    logic [7:0]    prev_byte;
    logic [7:0]    gap_cnt;
    state_t        state;
    state_t        state_nxt;

    logic        wr_ok;
    logic        wr_drop;
    logic        commit;
    logic        lost;
    logic        pkt_nonempty;
    logic        flag_fix;
    logic        discard;
    logic        pkt_add;
    logic        pkt_start;
    logic        pop;
    logic        pop_last;
    logic        rlast_peek;
    logic        ram_we;
    logic [AW-1:0] ram_waddr;
    fifo_entry_t ram_wdata;

    // ---------------------------------------------------------------
    // Write side
    // ---------------------------------------------------------------
    assign full         = (wr_ptr - rd_ptr) == PW'(DEPTH);
    assign wr_ok        = wr_en && !full;
    assign wr_drop      = wr_en && full;
    assign commit       = wr_en && wr_last;
    // A dropped wr_last byte is itself a lost byte.
    assign lost         = ovf_pend || wr_drop;
    assign pkt_nonempty = wr_ptr != commit_ptr;
    assign overflow     = commit && lost;
    assign wr_ptr_prev  = wr_ptr - PW'(1);
    assign wr_ptr_after = wr_ok ? (wr_ptr + PW'(1)) : wr_ptr;

`ifdef TX_FIFO_OVF_DROP_EN
    assign flag_fix = 1'b0;
    assign discard  = commit && lost;
    assign pkt_add  = commit && !lost;
`else
    // The wr_last byte was dropped: mark the newest stored byte as the end
    // of the packet by rewriting it with its saved data byte.
    assign flag_fix = wr_drop && wr_last && pkt_nonempty;
    assign discard  = 1'b0;
    // A packet whose every byte was dropped is not committed.
    assign pkt_add  = commit && (wr_ok || pkt_nonempty);
`endif

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_ptr[AW-1:0];
        ram_wdata = '{last: wr_last, data: wr_data};
        if (wr_ok) begin
            ram_we = 1'b1;
        end else if (flag_fix) begin
            ram_we    = 1'b1;
            ram_waddr = wr_ptr_prev[AW-1:0];
            ram_wdata = '{last: 1'b1, data: prev_byte};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            ovf_pend   <= 1'b0;
            prev_byte  <= '0;
        end else begin
            if (discard) begin
                wr_ptr <= commit_ptr;
            end else if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pkt_add) begin
                commit_ptr <= wr_ptr_after;
            end
            if (commit) begin
                ovf_pend <= 1'b0;
            end else if (wr_drop) begin
                ovf_pend <= 1'b1;
            end
            if (wr_ok) begin
                prev_byte <= wr_data;
            end
        end
    end

    // ---------------------------------------------------------------
    // Packet counter: commit and start in the same cycle cancel out.
    // ---------------------------------------------------------------
    assign pkt_start = (state == READY) && rd_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count <= '0;
        end else begin
            case ({pkt_add, pkt_start})
                2'b10:   pkt_count <= pkt_count + PW'(1);
                2'b01:   pkt_count <= pkt_count - PW'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Read side
    // ---------------------------------------------------------------
    // The commit_ptr guard keeps the reader out of uncommitted bytes.
    assign pop      = (state == SEND) && rd_en && (rd_ptr != commit_ptr);
    assign pop_last = pop && rlast_peek;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (pop_last) begin
            gap_cnt <= 8'(IFG_CYCLES);
        end else if ((state == GAP) && (gap_cnt != 8'd0)) begin
            gap_cnt <= gap_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        data_ready = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_count != '0) begin
                    state_nxt  = READY;
                    data_ready = 1'b1;
                end
            end
            READY: begin
                if (rd_start) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (pop_last) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0) begin
                    if (pkt_count != '0) begin
                        state_nxt  = READY;
                        data_ready = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fifo_empty = (state != SEND);
    assign dbg_state  = state;

    tx_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk        (clk),
        .rst        (reset),
        .we         (ram_we),
        .waddr      (ram_waddr),
        .wdata      (ram_wdata),
        .re         (pop),
        .raddr      (rd_ptr[AW-1:0]),
        .rdata      (rd_data),
        .rlast_peek (rlast_peek)
    );

endmodule

// File: tb/tb_tx_packet_fifo.sv
// tb_tx_packet_fifo: self-checking bench for tx_packet_fifo. The reference
// model tracks stored bytes as queues of packets; expected send order lives
// in exp_q as {last, data} entries.
module tb_tx_packet_fifo;
    import tx_fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int IFG   = 5;
    localparam int PW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          wr_last;
    logic          full;
    logic          overflow;
    logic          data_ready;
    logic          rd_start;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          fifo_empty;
    logic [PW-1:0] pkt_count;
    state_t        dbg_state;

    always #5 clk = ~clk;

    tx_packet_fifo #(
        .DEPTH      (DEPTH),
        .IFG_CYCLES (IFG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .full       (full),
        .overflow   (overflow),
        .data_ready (data_ready),
        .rd_start   (rd_start),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .fifo_empty (fifo_empty),
        .pkt_count  (pkt_count),
        .dbg_state  (dbg_state)
    );

    int tests_run;
    int tests_failed;

    // ---------------- monitors ----------------
    int cyc;
    int dr_count;
    int dr_cycle;
    int ovf_count;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_ready === 1'b1) begin
            dr_count++;
            dr_cycle = cyc;
        end
        if (overflow === 1'b1) ovf_count++;
    end

    // ---------------- reference model ----------------
    logic [8:0] exp_q[$];
    logic [7:0] cur_q[$];
    int         m_used;
    bit         m_ovf;
    int         m_ovf_pulses;

    task automatic model_clear();
        exp_q.delete();
        cur_q.delete();
        m_used = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_write(input logic [7:0] d, input bit last);
        bit lost;
        if (m_used >= DEPTH) m_ovf = 1'b1;
        else begin
            cur_q.push_back(d);
            m_used++;
        end
        if (last) begin
            lost  = m_ovf;
            m_ovf = 1'b0;
            if (lost) m_ovf_pulses++;
`ifdef TX_FIFO_OVF_DROP_EN
            if (lost) begin
                m_used -= cur_q.size();
                cur_q.delete();
            end
`endif
            foreach (cur_q[i]) exp_q.push_back({(i == cur_q.size() - 1), cur_q[i]});
            cur_q.delete();
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        rd_start = 1'b0;
        rd_en    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_clear();
        tick();
    endtask

    task automatic do_write(input logic [7:0] d, input bit last);
        wr_en   = 1'b1;
        wr_data = d;
        wr_last = last;
        tick();
        wr_en   = 1'b0;
        wr_last = 1'b0;
        model_write(d, last);
    endtask

    task automatic start_packet();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
    endtask

    task automatic pop_one(output logic [7:0] d, output logic e);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        d = rd_data;
        e = fifo_empty;
        m_used--;
    endtask

    task automatic wait_ready(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dr_count != base) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        tests_run++;
        if (rd_data !== 8'h00 || fifo_empty !== 1'b1 || data_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_read_side: rd_data=%h fifo_empty=%b data_ready=%b, expected 00 1 0", rd_data, fifo_empty, data_ready);
        end
        tests_run++;
        if (pkt_count !== '0 || full !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_write_side: pkt_count=%0d full=%b overflow=%b, expected 0 0 0", pkt_count, full, overflow);
        end
        tests_run++;
        if (dbg_state !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
        end
    endtask

    task automatic test_basic();
        int base;
        bit ok;
        logic [7:0] d;
        logic e;
        logic [8:0] exp;
        do_reset();
        base = dr_count;
        do_write(8'hAB, 1'b0);
        do_write(8'hCD, 1'b0);
        do_write(8'hEF, 1'b1);
        tests_run++;
        if (pkt_count !== PW'(1)) begin
            tests_failed++;
            $display("FAIL basic_pkt_count: got %0d expected 1", pkt_count);
        end
        wait_ready(base, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL basic_ready_timeout: data_ready count %0d expected %0d", dr_count - base, 1);
        end
        start_packet();
        for (int i = 0; i < 3; i++) begin
            pop_one(d, e);
            exp = exp_q.pop_front();
            tests_run++;
            if (d !== exp[7:0] || e !== exp[8]) begin
                tests_failed++;
                $display("FAIL basic_byte%0d: data=%h empty=%b, expected %h %b", i, d, e, exp[7:0], exp[8]);
            end
        end
        repeat (IFG + 4) tick();
        tests_run++;
        if (dr_count - base !== 1 || pkt_count !== '0 || dbg_state !== IDLE) begin
            tests_failed++;
            $display("FAIL basic_after: pulses=%0d pkt_count=%0d state=%0d, expected 1 0 %0d", dr_count - base, pkt_count, dbg_state, IDLE);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int t_pop;
        bit ok;
        logic [7:0] d;
        logic e;
        logic [8:0] exp;
        do_reset();
        base = dr_count;
        for (int i = 0; i < 4; i++) do_write(8'($urandom_range(0, 255)), (i % 2) == 1);
        tests_run++;
        if (pkt_count !== PW'(2)) begin
            tests_failed++;
            $display("FAIL b2b_pkt_count: got %0d expected 2", pkt_count);
        end
        tests_run++;
        if (dr_count - base !== 1) begin
            tests_failed++;
            $display("FAIL b2b_first_offer: pulses=%0d expected 1", dr_count - base);
        end
        start_packet();
        tests_run++;
        if (pkt_count !== PW'(1)) begin
            tests_failed++;
            $display("FAIL b2b_pkt_count_after_start: got %0d expected 1", pkt_count);
        end
        t_pop = 0;
        for (int pk = 0; pk < 2; pk++) begin
            if (pk == 1) begin
                wait_ready(base + 1, ok);
                tests_run++;
                if (!ok || dr_cycle != t_pop + IFG) begin
                    tests_failed++;
                    $display("FAIL b2b_gap: offer cycle=%0d expected %0d (seen=%b)", dr_cycle, t_pop + IFG, ok);
                end
                start_packet();
            end
            for (int i = 0; i < 2; i++) begin
                pop_one(d, e);
                exp = exp_q.pop_front();
                tests_run++;
                if (d !== exp[7:0] || e !== exp[8]) begin
                    tests_failed++;
                    $display("FAIL b2b_pkt%0d_byte%0d: data=%h empty=%b, expected %h %b", pk, i, d, e, exp[7:0], exp[8]);
                end
            end
            t_pop = cyc;
        end
    endtask

    task automatic test_overflow();
        int base_dr;
        int base_ovf;
        int exp_ovf;
        logic [7:0] d;
        logic e;
        logic [8:0] exp;
`ifndef TX_FIFO_OVF_DROP_EN
        bit ok;
`endif
        do_reset();
        base_dr  = dr_count;
        base_ovf = ovf_count;
        exp_ovf  = m_ovf_pulses;
        for (int i = 0; i < DEPTH - 1; i++) do_write(8'($urandom_range(0, 255)), 1'b0);
        tests_run++;
        if (full !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_full_early: got %b expected 0", full);
        end
        do_write(8'($urandom_range(0, 255)), 1'b0);
        tests_run++;
        if (full !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_full_at_depth: got %b expected 1", full);
        end
        do_write(8'($urandom_range(0, 255)), 1'b0);
        do_write(8'($urandom_range(0, 255)), 1'b0);
        do_write(8'($urandom_range(0, 255)), 1'b1);
        tests_run++;
        if (ovf_count - base_ovf !== m_ovf_pulses - exp_ovf) begin
            tests_failed++;
            $display("FAIL ovf_pulses: got %0d expected %0d", ovf_count - base_ovf, m_ovf_pulses - exp_ovf);
        end
`ifdef TX_FIFO_OVF_DROP_EN
        repeat (IFG + 5) tick();
        tests_run++;
        if (pkt_count !== '0 || full !== 1'b0 || dr_count != base_dr) begin
            tests_failed++;
            $display("FAIL ovf_drop: pkt_count=%0d full=%b offers=%0d, expected 0 0 0", pkt_count, full, dr_count - base_dr);
        end
`else
        tests_run++;
        if (pkt_count !== PW'(1)) begin
            tests_failed++;
            $display("FAIL ovf_pkt_count: got %0d expected 1", pkt_count);
        end
        wait_ready(base_dr, ok);
        start_packet();
        for (int i = 0; i < DEPTH; i++) begin
            if (exp_q.size() == 0) break;
            pop_one(d, e);
            exp = exp_q.pop_front();
            tests_run++;
            if (d !== exp[7:0] || e !== exp[8]) begin
                tests_failed++;
                $display("FAIL ovf_byte%0d: data=%h empty=%b, expected %h %b", i, d, e, exp[7:0], exp[8]);
            end
        end
`endif
    endtask

    task automatic test_rd_en_hold();
        int base;
        bit ok;
        logic [7:0] d;
        logic e;
        logic [8:0] exp;
        logic [7:0] last_popped;
        do_reset();
        last_popped = 8'h00;
        base = dr_count;
        do_write(8'($urandom_range(0, 255)), 1'b0);
        do_write(8'($urandom_range(0, 255)), 1'b1);
        wait_ready(base, ok);
        rd_en = 1'b1;
        repeat (3) tick();
        rd_en = 1'b0;
        tests_run++;
        if (rd_data !== last_popped || fifo_empty !== 1'b1 || dbg_state !== READY) begin
            tests_failed++;
            $display("FAIL hold_ready: rd_data=%h empty=%b state=%0d, expected %h 1 %0d", rd_data, fifo_empty, dbg_state, last_popped, READY);
        end
        start_packet();
        for (int i = 0; i < 2; i++) begin
            pop_one(d, e);
            exp = exp_q.pop_front();
            last_popped = exp[7:0];
            tests_run++;
            if (d !== exp[7:0] || e !== exp[8]) begin
                tests_failed++;
                $display("FAIL hold_byte%0d: data=%h empty=%b, expected %h %b", i, d, e, exp[7:0], exp[8]);
            end
        end
        rd_en = 1'b1;
        repeat (IFG - 1) tick();
        tests_run++;
        if (rd_data !== last_popped || fifo_empty !== 1'b1 || dbg_state !== GAP) begin
            tests_failed++;
            $display("FAIL hold_gap: rd_data=%h empty=%b state=%0d, expected %h 1 %0d", rd_data, fifo_empty, dbg_state, last_popped, GAP);
        end
        rd_en = 1'b0;
        repeat (IFG + 2) tick();
        base = dr_count;
        do_write(8'($urandom_range(0, 255)), 1'b1);
        wait_ready(base, ok);
        start_packet();
        pop_one(d, e);
        exp = exp_q.pop_front();
        tests_run++;
        if (!ok || d !== exp[7:0] || e !== exp[8]) begin
            tests_failed++;
            $display("FAIL hold_next_pkt: data=%h empty=%b offered=%b, expected %h %b 1", d, e, ok, exp[7:0], exp[8]);
        end
    endtask

    task automatic test_commit_with_start();
        int base;
        bit ok;
        logic [7:0] d;
        logic [7:0] b;
        logic e;
        logic [8:0] exp;
        do_reset();
        base = dr_count;
        do_write(8'($urandom_range(0, 255)), 1'b0);
        do_write(8'($urandom_range(0, 255)), 1'b1);
        wait_ready(base, ok);
        do_write(8'($urandom_range(0, 255)), 1'b0);
        b        = 8'($urandom_range(0, 255));
        wr_en    = 1'b1;
        wr_data  = b;
        wr_last  = 1'b1;
        rd_start = 1'b1;
        tick();
        wr_en    = 1'b0;
        wr_last  = 1'b0;
        rd_start = 1'b0;
        model_write(b, 1'b1);
        tests_run++;
        if (pkt_count !== PW'(1) || dbg_state !== SEND) begin
            tests_failed++;
            $display("FAIL cws_pkt_count: pkt_count=%0d state=%0d, expected 1 %0d", pkt_count, dbg_state, SEND);
        end
        for (int pk = 0; pk < 2; pk++) begin
            if (pk == 1) begin
                wait_ready(base + 1, ok);
                start_packet();
                tests_run++;
                if (!ok || pkt_count !== '0) begin
                    tests_failed++;
                    $display("FAIL cws_second_offer: offered=%b pkt_count=%0d, expected 1 0", ok, pkt_count);
                end
            end
            for (int i = 0; i < 2; i++) begin
                pop_one(d, e);
                exp = exp_q.pop_front();
                tests_run++;
                if (d !== exp[7:0] || e !== exp[8]) begin
                    tests_failed++;
                    $display("FAIL cws_pkt%0d_byte%0d: data=%h empty=%b, expected %h %b", pk, i, d, e, exp[7:0], exp[8]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_send();
        int base;
        bit ok;
        logic [7:0] d;
        logic e;
        logic [8:0] exp;
        do_reset();
        base = dr_count;
        for (int i = 0; i < 6; i++) do_write(8'($urandom_range(0, 255)), i == 5);
        for (int i = 0; i < 3; i++) do_write(8'($urandom_range(0, 255)), i == 2);
        wait_ready(base, ok);
        start_packet();
        pop_one(d, e);
        pop_one(d, e);
        reset = 1'b1;
        #1;
        tests_run++;
        if (rd_data !== 8'h00 || fifo_empty !== 1'b1 || data_ready !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_read: rd_data=%h empty=%b ready=%b ovf=%b, expected 00 1 0 0", rd_data, fifo_empty, data_ready, overflow);
        end
        tests_run++;
        if (pkt_count !== '0 || full !== 1'b0 || dbg_state !== IDLE) begin
            tests_failed++;
            $display("FAIL rst_mid_write: pkt_count=%0d full=%b state=%0d, expected 0 0 %0d", pkt_count, full, dbg_state, IDLE);
        end
        tick();
        reset = 1'b0;
        model_clear();
        base = dr_count;
        repeat (30) tick();
        tests_run++;
        if (dr_count != base) begin
            tests_failed++;
            $display("FAIL rst_no_offer: offers=%0d expected 0", dr_count - base);
        end
        do_write(8'($urandom_range(0, 255)), 1'b0);
        do_write(8'($urandom_range(0, 255)), 1'b1);
        wait_ready(base, ok);
        start_packet();
        for (int i = 0; i < 2; i++) begin
            pop_one(d, e);
            exp = exp_q.pop_front();
            tests_run++;
            if (!ok || d !== exp[7:0] || e !== exp[8]) begin
                tests_failed++;
                $display("FAIL rst_new_byte%0d: data=%h empty=%b offered=%b, expected %h %b 1", i, d, e, ok, exp[7:0], exp[8]);
            end
        end
    endtask

    task automatic test_random();
        int base;
        int served;
        int npk;
        int len;
        bit ok;
        logic [7:0] d;
        logic e;
        logic [8:0] exp;
        do_reset();
        base   = dr_count;
        served = 0;
        for (int round = 0; round < 4; round++) begin
            npk = $urandom_range(1, 3);
            for (int p = 0; p < npk; p++) begin
                len = $urandom_range(1, 4);
                for (int i = 0; i < len; i++) do_write(8'($urandom_range(0, 255)), i == len - 1);
            end
            for (int p = 0; p < npk; p++) begin
                wait_ready(base + served, ok);
                tests_run++;
                if (!ok) begin
                    tests_failed++;
                    $display("FAIL rand_offer: round %0d packet %0d not offered", round, p);
                end
                start_packet();
                served++;
                for (int i = 0; i < DEPTH; i++) begin
                    if (exp_q.size() == 0) break;
                    if ($urandom_range(0, 1) == 0) tick();
                    pop_one(d, e);
                    exp = exp_q.pop_front();
                    tests_run++;
                    if (d !== exp[7:0] || e !== exp[8]) begin
                        tests_failed++;
                        $display("FAIL rand_byte: round %0d data=%h empty=%b, expected %h %b", round, d, e, exp[7:0], exp[8]);
                    end
                    if (exp[8]) break;
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_ovf_pulses = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_rd_en_hold();
        test_commit_with_start();
        test_reset_mid_send();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
